mem_bus_ifc: RTL and testbench

//  Memory bus interface between the PUNEH controller/datapath and external memory.

---
 rtl/puneh_bus_pkg.sv | 13 +
 rtl/bus_wait_timer.sv | 28 ++
 rtl/mem_bus_ifc.sv | 102 ++++++++++
 tb/tb_mem_bus_ifc.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/puneh_bus_pkg.sv
// Shared types and widths for the PUNEH memory bus interface.
package puneh_bus_pkg;

  localparam int PUNEH_DW = 16;
  localparam int PUNEH_AW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter for a bus access; expired fires on the enabled cycle
// that brings the count up to TIMEOUT.
module bus_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_ifc.sv
// Single-request memory bus interface: IDLE -> ACCESS -> DONE.
// Optional access timeout enabled by defining BUS_TIMEOUT_EN.
module mem_bus_ifc
  import puneh_bus_pkg::*;
#(
  parameter int DW      = PUNEH_DW,
  parameter int AW      = PUNEH_AW,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic          wr_req,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_oe,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  state_e        state_q;
  logic          busy_q, done_q, err_q, rd_q, wr_q;
  logic [DW-1:0] rdata_q, wdata_q;
  logic [AW-1:0] addr_q;
  logic          expired;

`ifdef BUS_TIMEOUT_EN
  bus_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != ACCESS),
    .en      ((state_q == ACCESS) && !mem_ready),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_req || wr_req) begin
            // A simultaneous write is dropped; the read wins.
            addr_q  <= addr;
            rd_q    <= rd_req;
            wr_q    <= !rd_req;
            busy_q  <= 1'b1;
            if (!rd_req) wdata_q <= wdata;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ready || expired) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= !mem_ready;
            if (mem_ready && rd_q) rdata_q <= mem_rdata;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_oe    = wr_q;

endmodule

// File: tb/tb_mem_bus_ifc.sv
// Directed bench for mem_bus_ifc; covers the timeout path when BUS_TIMEOUT_EN is defined.
module tb_mem_bus_ifc;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req;
  logic [15:0] addr, wdata;
  logic        busy, done, err;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic        mem_oe, mem_rd, mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  mem_bus_ifc #(.DW(16), .AW(16), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_oe    (mem_oe),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  // Each tick lands on a falling edge: outputs are sampled and inputs driven there.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] d);
    rd_req = 1'b1; addr = a;
    tick();
    rd_req = 1'b0; mem_ready = 1'b1; mem_rdata = d;
    tick();
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [69:0] all;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    tick(); tick();
    all = {busy, done, err, rdata, mem_addr, mem_wdata, mem_oe, mem_rd, mem_wr};
    checks++;
    if (all !== 70'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_zero_wait();
    rd_req = 1'b1; addr = 16'h0040;
    tick();
    rd_req = 1'b0; addr = 16'hFFFF;
    checks++;
    if ({mem_rd, mem_wr, busy, done, mem_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 16'h0040}) begin
      errors++; $display("FAIL rd0_cycle1: got rd=%b wr=%b busy=%b done=%b addr=%h want 1 0 1 0 0040",
                          mem_rd, mem_wr, busy, done, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    checks++;
    if ({mem_rd, busy, done, err, rdata} !== {1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF}) begin
      errors++; $display("FAIL rd0_cycle2: got rd=%b busy=%b done=%b err=%b rdata=%h want 0 0 1 0 beef",
                          mem_rd, busy, done, err, rdata);
    end
    tick();
    checks++;
    if ({done, rdata} !== {1'b0, 16'hBEEF}) begin
      errors++; $display("FAIL rd0_cycle3: got done=%b rdata=%h want 0 beef", done, rdata);
    end
  endtask

  task automatic test_write_wait();
    int bad = 0;
    wr_req = 1'b1; addr = 16'h0100; wdata = 16'h1234;
    tick();
    wr_req = 1'b0; wdata = 16'h0000;
    for (int c = 1; c <= 4; c++) begin
      if ({mem_wr, mem_oe, mem_rd, busy, done, mem_wdata, mem_addr} !==
          {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0100}) begin
        bad++;
        $display("FAIL wr_wait_c%0d: got wr=%b oe=%b rd=%b busy=%b done=%b wd=%h a=%h want 1 1 0 1 0 1234 0100",
                 c, mem_wr, mem_oe, mem_rd, busy, done, mem_wdata, mem_addr);
      end
      if (c == 4) mem_ready = 1'b1;
      tick();
    end
    checks++;
    if (bad != 0) errors++;
    mem_ready = 1'b0;
    checks++;
    if ({mem_wr, mem_oe, busy, done, err, rdata} !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF}) begin
      errors++; $display("FAIL wr_done: got wr=%b oe=%b busy=%b done=%b err=%b rdata=%h want 0 0 0 1 0 beef",
                          mem_wr, mem_oe, busy, done, err, rdata);
    end
    tick();
    checks++;
    if ({done, mem_addr, mem_wdata} !== {1'b0, 16'h0100, 16'h1234}) begin
      errors++; $display("FAIL wr_idle_hold: got done=%b a=%h wd=%h want 0 0100 1234", done, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_collision();
    rd_req = 1'b1; wr_req = 1'b1; addr = 16'h0200; wdata = 16'h5555;
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    checks++;
    if ({mem_rd, mem_wr, mem_oe, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b0, 16'h0200, 16'h1234}) begin
      errors++; $display("FAIL coll_strobe: got rd=%b wr=%b oe=%b a=%h wd=%h want 1 0 0 0200 1234",
                          mem_rd, mem_wr, mem_oe, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    // DONE cycle: new request and a lingering mem_ready must both be ignored.
    rd_req = 1'b1; addr = 16'h0999; mem_rdata = 16'h1111;
    checks++;
    if ({done, rdata} !== {1'b1, 16'hCAFE}) begin
      errors++; $display("FAIL coll_done: got done=%b rdata=%h want 1 cafe", done, rdata);
    end
    tick();
    rd_req = 1'b0; mem_ready = 1'b0;
    checks++;
    if ({mem_rd, busy, done, rdata, mem_addr} !== {1'b0, 1'b0, 1'b0, 16'hCAFE, 16'h0200}) begin
      errors++; $display("FAIL coll_ignore_in_done: got rd=%b busy=%b done=%b rdata=%h a=%h want 0 0 0 cafe 0200",
                          mem_rd, busy, done, rdata, mem_addr);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [69:0] all;
    int bad = 0;
    rd_req = 1'b1; addr = 16'h0300;
    tick();
    rd_req = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if ({mem_rd, busy} !== 2'b11) begin
      errors++; $display("FAIL rstmid_pre: got rd=%b busy=%b want 1 1", mem_rd, busy);
    end
    mem_ready = 1'b1; mem_rdata = 16'h4444;
    tick();
    rst = 1'b0; mem_ready = 1'b0;
    all = {busy, done, err, rdata, mem_addr, mem_wdata, mem_oe, mem_rd, mem_wr};
    checks++;
    if (all !== 70'd0) begin
      errors++; $display("FAIL rstmid_outputs: got %h want 0", all);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if ({done, err} !== 2'b00) begin
        bad++; $display("FAIL rstmid_no_done: got done=%b err=%b want 0 0", done, err);
      end
    end
    checks++;
    if (bad != 0) errors++;
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    int bad = 0;
    do_read(16'h0010, 16'h7777);
    rd_req = 1'b1; addr = 16'h0400;
    tick();
    rd_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if ({mem_rd, busy, done, err} !== 4'b1100) begin
        bad++; $display("FAIL to_wait_c%0d: got rd=%b busy=%b done=%b err=%b want 1 1 0 0",
                        c, mem_rd, busy, done, err);
      end
      tick();
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if ({mem_rd, busy, done, err, rdata} !== {4'b0011, 16'h7777}) begin
      errors++; $display("FAIL to_abort: got rd=%b busy=%b done=%b err=%b rdata=%h want 0 0 1 1 7777",
                          mem_rd, busy, done, err, rdata);
    end
    tick();
    checks++;
    if ({done, err} !== 2'b00) begin
      errors++; $display("FAIL to_pulse_len: got done=%b err=%b want 0 0", done, err);
    end
    // Ready on the same edge the count reaches the limit completes normally.
    rd_req = 1'b1; addr = 16'h0500;
    tick();
    rd_req = 1'b0;
    tick(); tick(); tick();
    mem_ready = 1'b1; mem_rdata = 16'h2468;
    tick();
    mem_ready = 1'b0;
    checks++;
    if ({done, err, rdata} !== {2'b10, 16'h2468}) begin
      errors++; $display("FAIL to_edge_ready: got done=%b err=%b rdata=%h want 1 0 2468", done, err, rdata);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int bad = 0;
    do_read(16'h0010, 16'h7777);
    rd_req = 1'b1; addr = 16'h0400;
    tick();
    rd_req = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if ({mem_rd, busy, done, err} !== 4'b1100) begin
        bad++;
        if (bad < 4) $display("FAIL nto_wait_c%0d: got rd=%b busy=%b done=%b err=%b want 1 1 0 0",
                              c, mem_rd, busy, done, err);
      end
      tick();
    end
    checks++;
    if (bad != 0) errors++;
    mem_ready = 1'b1; mem_rdata = 16'h1357;
    tick();
    mem_ready = 1'b0;
    checks++;
    if ({busy, done, err, rdata} !== {3'b010, 16'h1357}) begin
      errors++; $display("FAIL nto_complete: got busy=%b done=%b err=%b rdata=%h want 0 1 0 1357",
                          busy, done, err, rdata);
    end
    tick();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_collision();
    test_reset_mid();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
